// File: rtl/tdm_demux_16.sv
// rtl/tdm_demux_16.sv - 1:16 time-division demultiplexer with valid/ready frame output.
// Optional TDM_DEMUX_FREERUN_EN: consecutive frames run back-to-back without sof.
module tdm_demux_16 #(
    parameter int DATA_W = 1,
    parameter int SLOTS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    input  logic                    sof,
    output logic [3:0]              slot,
    output logic [SLOTS*DATA_W-1:0] frame,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun,
    output logic                    sync_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              slot_q, slot_d;
    logic [SLOTS*DATA_W-1:0] buf_q, buf_d;
    logic [SLOTS*DATA_W-1:0] frame_q, frame_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    sync_err_q, sync_err_d;
    logic                    complete;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        buf_d         = buf_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = 1'b0;
        sync_err_d    = 1'b0;
        complete      = 1'b0;

        if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end

        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        buf_d[0 +: DATA_W] = din;
                        slot_d             = 4'd1;
                        state_d            = COLLECT;
                    end
                end
                COLLECT: begin
                    if (sof) begin
                        // Resync: stale upper slots are simply overwritten later.
                        buf_d[0 +: DATA_W] = din;
                        slot_d             = 4'd1;
                        sync_err_d         = (slot_q != 4'd0);
                    end else begin
                        buf_d[int'(slot_q)*DATA_W +: DATA_W] = din;
                        slot_d = slot_q + 4'd1;
                        if (slot_q == 4'(SLOTS-1)) begin
                            complete = 1'b1;
`ifdef TDM_DEMUX_FREERUN_EN
                            state_d  = COLLECT;
`else
                            state_d  = IDLE;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A completed frame loads only if the output slot is free or draining now.
        if (complete) begin
            if (!frame_valid_q || frame_ready) begin
                frame_d       = buf_d;
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            slot_q        <= 4'd0;
            buf_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            buf_q         <= buf_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign slot        = slot_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_16.sv
// tb/tb_tdm_demux_16.sv - directed-vector bench for tdm_demux_16 (DATA_W=1).
module tb_tdm_demux_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  din;
    logic        din_valid;
    logic        sof;
    logic [3:0]  slot;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;
    logic        sync_err;

    int n_vec = 0;
    int n_bad = 0;
    int ovr_cnt;
    int serr_cnt;

    tdm_demux_16 dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .slot       (slot),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun    (overrun),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ovr_cnt  += int'(overrun);
        serr_cnt += int'(sync_err);
    endtask

    task automatic sample(input logic b, input logic s);
        din       = b;
        sof       = s;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            sample(v[i], i == 0);
        end
    endtask

    task automatic consume();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; din = '0; din_valid = 1'b0; sof = 1'b0; frame_ready = 1'b0;
        ovr_cnt = 0; serr_cnt = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_slot", 32'(slot), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_serr", 32'(sync_err), 0);

        // Basic frame
        v = 16'hAAAA;
        for (int i = 0; i < 15; i++) sample(v[i], i == 0);
        chk("basic_fv_early", 32'(frame_valid), 0);
        chk("basic_slot15", 32'(slot), 15);
        sample(v[15], 1'b0);
        chk("basic_frame", 32'(frame), 32'hAAAA);
        chk("basic_fv", 32'(frame_valid), 1);
        chk("basic_slot0", 32'(slot), 0);
        consume();
        chk("basic_drain", 32'(frame_valid), 0);

        // Junk before sof, then gapped frame
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b0);
        chk("junk_slot", 32'(slot), 0);
        v = 16'h5A3C;
        for (int i = 0; i < 16; i++) begin
            sample(v[i], i == 0);
            if (i < 15) tick();
        end
        chk("gap_frame", 32'(frame), 32'h5A3C);
        chk("gap_fv", 32'(frame_valid), 1);
        consume();

        // Resync at sample 7
        serr_cnt = 0;
        v = 16'h1234;
        sample(1'b1, 1'b1);
        for (int i = 1; i < 7; i++) sample(1'b1, 1'b0);
        sample(v[0], 1'b1);
        chk("resync_pulse", 32'(sync_err), 1);
        chk("resync_slot", 32'(slot), 1);
        for (int i = 1; i < 16; i++) sample(v[i], 1'b0);
        chk("resync_count", 32'(serr_cnt), 1);
        chk("resync_frame", 32'(frame), 32'h1234);
        consume();

        // Overrun with ready low
        ovr_cnt = 0;
        send_frame(16'hFFFF);
        send_frame(16'h0000);
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_frame", 32'(frame), 32'hFFFF);
        chk("ovr_fv", 32'(frame_valid), 1);
        tick();
        chk("ovr_count", 32'(ovr_cnt), 1);
        chk("ovr_frame_hold", 32'(frame), 32'hFFFF);

        // Completion coincident with a transfer
        ovr_cnt = 0;
        for (int i = 0; i < 15; i++) sample(1'b0, i == 0);
        frame_ready = 1'b1;
        sample(1'b0, 1'b0);
        frame_ready = 1'b0;
        chk("pass_frame", 32'(frame), 32'h0000);
        chk("pass_fv", 32'(frame_valid), 1);
        chk("pass_ovr", 32'(ovr_cnt), 0);
        consume();

        // Reset mid-frame with a pending frame
        send_frame(16'h8001);
        for (int i = 0; i < 9; i++) sample(1'b1, i == 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_slot", 32'(slot), 0);
        chk("mrst_frame", 32'(frame), 0);
        chk("mrst_fv", 32'(frame_valid), 0);
        sample(1'b1, 1'b0);
        chk("mrst_idle", 32'(slot), 0);
        send_frame(16'hC0DE);
        chk("mrst_newframe", 32'(frame), 32'hC0DE);
        chk("mrst_newfv", 32'(frame_valid), 1);
        consume();

`ifdef TDM_DEMUX_FREERUN_EN
        serr_cnt = 0;
        frame_ready = 1'b1;
        v = 16'hBEEF;
        for (int i = 0; i < 16; i++) sample(v[i], i == 0);
        chk("free_f1", 32'(frame), 32'hBEEF);
        chk("free_fv1", 32'(frame_valid), 1);
        v = 16'hF00D;
        for (int i = 0; i < 15; i++) sample(v[i], 1'b0);
        chk("free_fv_gap", 32'(frame_valid), 0);
        sample(v[15], 1'b0);
        chk("free_f2", 32'(frame), 32'hF00D);
        chk("free_fv2", 32'(frame_valid), 1);
        chk("free_serr", 32'(serr_cnt), 0);
        frame_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_16.md
Name: tdm_demux_16

Overview:
- Sequential 1-to-16 time-division demultiplexer. It is the receive-side counterpart of the team's 16:1 mux.
- It accepts one slot sample per valid cycle on a serial input, steers each sample into the slot selected by an internal slot counter, and presents the full 16-slot frame on a parallel output with a valid/ready handshake.
- It sits downstream of any mux-based serialiser.

Parameters:
- DATA_W, 1: width of one slot sample.
- SLOTS, 16: slots per frame. Fixed at 16; the slot index is 4 bits.

Ports:
- clk  input  1  : clock; all logic is on the rising edge.
- rst  input  1  : synchronous, active-high reset.
- din  input  DATA_W  : slot sample.
- din_valid  input  1  : din is valid this cycle.
- sof  input  1  : start of frame; qualified by din_valid; marks din as slot 0.
- slot  output  4  : slot index the next accepted sample is written to.
- frame  output  16*DATA_W  : assembled frame; slot i occupies bits [i*DATA_W +: DATA_W].
- frame_valid  output  1  : frame holds an unconsumed frame.
- frame_ready  input  1  : consumer accepts the frame.
- overrun  output  1  : one-cycle pulse when a completed frame is dropped.
- sync_err  output  1  : one-cycle pulse when sof arrives mid-frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: slot=0, frame=0, frame_valid=0, overrun=0, sync_err=0, internal assembly buffer=0, state=IDLE. Reset asserted mid-frame discards the partial frame and any pending output frame.
- States:
  - IDLE: waiting for sof.
  - COLLECT: assembling a frame.
- IDLE:
  - din_valid=0, or din_valid=1 with sof=0: sample discarded, no state change, slot stays 0.
  - din_valid=1 with sof=1: din written to buffer slot 0; slot becomes 1; go to COLLECT.
- COLLECT, din_valid=1, sof=0:
  - din written to buffer[slot]; slot increments.
  - If slot==15, the frame is complete: slot wraps to 0 and the state goes to IDLE.
- COLLECT, din_valid=1, sof=1:
  - Resynchronise: din is written to slot 0 and slot becomes 1.
  - sync_err pulses for one cycle.
  - Stale contents of slots 1..15 are overwritten as the new frame fills; no explicit clear.
- COLLECT, din_valid=0: hold all state. Gaps between samples are unlimited.
- Frame completion (slot-15 sample accepted in cycle N):
  - In cycle N+1, frame equals the buffer including the slot-15 sample, and frame_valid=1.
  - Latency from the slot-15 sample to frame_valid is 1 cycle.
- Output handshake:
  - A transfer occurs on a cycle with frame_valid && frame_ready; frame_valid falls in the following cycle unless a new frame loads.
  - frame is stable while frame_valid=1 and no transfer has occurred.
- Simultaneous events:
  - Completion while frame_valid=1 and frame_ready=1 in the same cycle: the new frame loads, frame_valid stays 1, no overrun.
  - Completion while frame_valid=1 and frame_ready=0: the new frame is dropped, frame is unchanged, and overrun pulses in cycle N+1.
- sof on the slot-15 cycle: treated as resync, so the frame is not completed, sync_err pulses, and slot becomes 1.
- The slot output reflects the registered counter only; it has no combinational path from inputs.

Optional Feature:
- Macro: TDM_DEMUX_FREERUN_EN.
- Defined: after slot 15 the state stays in COLLECT with slot=0, so consecutive frames need no sof. sof still resynchronises, with sync_err when slot!=0. sof at slot 0 in COLLECT is legal and raises no sync_err.
- Undefined: every frame must begin with sof. Samples after completion are discarded until the next sof, as described above.

Test Plan:
- Basic frame, DATA_W=1: reset, then 16 consecutive valid cycles with sof on the first and din = bit i of 16'hAAAA on sample i. Required: frame=16'hAAAA and frame_valid=1 exactly one cycle after the 16th sample; slot returns to 0; frame_ready=1 clears frame_valid the next cycle.
- Gaps and pre-sof junk: 5 valid samples with sof=0 while IDLE, then a 16'h5A3C frame with din_valid low on alternate cycles. Required: the junk is ignored and frame=16'h5A3C.
- Resync: sof at sample 0, then sof again at sample 7, then 15 more samples of 16'h1234 (bit i on sample i, with the second sof carrying bit 0). Required: sync_err pulses once at the second sof and frame=16'h1234.
- Overrun: two back-to-back frames 16'hFFFF then 16'h0000 with frame_ready=0 throughout. Required: frame stays 16'hFFFF and overrun pulses once. Repeat with frame_ready=1 on the completion cycle: frame becomes 16'h0000 with no overrun and frame_valid held high.
- Reset mid-frame: rst for 1 cycle after 9 samples. Required: all outputs 0, state IDLE, and the next sof frame (16'hC0DE) assembles correctly.
- With TDM_DEMUX_FREERUN_EN: a single sof, then 32 samples forming 16'hBEEF then 16'hF00D. Required: two frames complete, 16 cycles apart, with no sync_err.
